// File: rtl/alisim_pkg.sv
// rtl/alisim_pkg.sv - shared phase codes, base encoding and seed mixing for the alignment simulator
package alisim_pkg;

  // Phase codes driven by Schedule; any code with bit 2 set means HOLD
  localparam logic [2:0] PH_IDLE  = 3'b000;
  localparam logic [2:0] PH_SEED  = 3'b001;
  localparam logic [2:0] PH_RUN   = 3'b010;
  localparam logic [2:0] PH_DRAIN = 3'b011;

  // Two-bit nucleotide encoding
  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  // Seed mixing constants; the low byte alone keeps the seeded word non-zero
  localparam logic [7:0] SEED_MIX_HI = 8'hA5;
  localparam logic [7:0] SEED_MIX_LO = 8'h5A;

  localparam logic [31:0] RNG_RESET = 32'h0000_0001;

  // A zero offset would reproduce the parent, so it is steered to the transition-like +2
  localparam logic [1:0] OFF_ZERO_REMAP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEDED,
    S_ACTIVE,
    S_DRAIN
  } mut_fsm_e;

  function automatic logic [31:0] seed_word(input logic [7:0] seed);
    return {seed, ~seed, seed ^ SEED_MIX_HI, SEED_MIX_LO};
  endfunction

  function automatic logic [1:0] mutate_base(input logic [1:0] parent, input logic [1:0] off);
    logic [1:0] eff;
    eff = (off == 2'd0) ? OFF_ZERO_REMAP : off;
    return parent + eff;
  endfunction

endpackage

// File: rtl/xorshift32.sv
// rtl/xorshift32.sv - 32-bit xorshift generator with synchronous load and single-step advance
module xorshift32
  import alisim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] s3;

  // One xorshift round: x^=x<<13; x^=x>>17; x^=x<<5
  always_comb begin
    s1 = value ^ (value << 13);
    s2 = s1 ^ (s1 >> 17);
    s3 = s2 ^ (s2 << 5);
  end

  // Load wins over step so a SEED never mixes with a pending advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RNG_RESET;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= s3;
    end
  end

endmodule

// File: rtl/site_mutator.sv
// rtl/site_mutator.sv - per-site random mutation of a base stream with registered output
module site_mutator
  import alisim_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state,
  input  logic [7:0]       seed_ID,
  input  logic [15:0]      threshold,
  input  logic [1:0]       in_base,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out_base,
  output logic             out_mut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] site_cnt,
  output logic [CNT_W-1:0] mut_cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mut_fsm_e    fsm;
  mut_fsm_e    fsm_next;
  logic        hold;
  logic        ph_idle;
  logic        ph_seed;
  logic        ph_run;
  logic        ph_drain;
  logic        accept;
  logic        drain_hs;
  logic        mutate;
  logic [1:0]  child_base;
  logic [31:0] seed_mix;
  logic [31:0] rng;
  logic        rng_unused;

  assign hold     = state[2];
  assign ph_idle  = (state == PH_IDLE);
  assign ph_seed  = (state == PH_SEED);
  assign ph_run   = (state == PH_RUN);
  assign ph_drain = (state == PH_DRAIN);

  assign accept   = in_valid && in_ready;
  // HOLD freezes the output register, so no handshake can complete there
  assign drain_hs = out_valid && out_ready && !hold;

  assign mutate     = (threshold == 16'hFFFF) || (rng[15:0] < threshold);
  assign child_base = mutate ? mutate_base(in_base, rng[17:16]) : in_base;
  assign seed_mix   = seed_word(seed_ID);
  assign rng_unused = ^rng[31:18];

  xorshift32 u_rng (
    .clk   (clk),
    .reset (reset),
    .load  (ph_seed),
    .step  (accept),
    .seed  (seed_mix),
    .value (rng)
  );

  // Next phase of the run and input backpressure; IDLE phase aborts from anywhere
  always_comb begin
    fsm_next = fsm;
    in_ready = 1'b0;
    case (fsm)
      S_IDLE:   if (ph_seed) fsm_next = S_SEEDED;
      S_SEEDED: if (ph_run) fsm_next = S_ACTIVE;
      S_ACTIVE: begin
        in_ready = ph_run && (!out_valid || out_ready);
        if (ph_drain) fsm_next = S_DRAIN;
      end
      S_DRAIN:  if (ph_drain && done) fsm_next = S_IDLE;
      default:  fsm_next = S_IDLE;
    endcase
    if (ph_idle) fsm_next = S_IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= S_IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Single-entry output register; a new site overwrites a slot being drained in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_base  <= BASE_A;
      out_mut   <= 1'b0;
    end else if (ph_idle) begin
      out_valid <= 1'b0;
      out_base  <= BASE_A;
      out_mut   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_base  <= child_base;
      out_mut   <= mutate;
    end else if (drain_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Site and mutation counters: cleared by SEED, saturating on accepted sites
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      site_cnt <= '0;
      mut_cnt  <= '0;
    end else if (ph_seed) begin
      site_cnt <= '0;
      mut_cnt  <= '0;
    end else if (accept) begin
      if (site_cnt != CNT_MAX) site_cnt <= site_cnt + 1'b1;
      if (mutate && (mut_cnt != CNT_MAX)) mut_cnt <= mut_cnt + 1'b1;
    end
  end

  // One-cycle done pulse in the cycle right after the output register empties during drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else if (!hold) begin
      done <= (fsm == S_DRAIN) && ph_drain && !done && !(out_valid && !out_ready);
    end
  end

endmodule

// File: tb/tb_site_mutator.sv
// tb/tb_site_mutator.sv - randomized self-checking bench for site_mutator
module tb_site_mutator;
  import alisim_pkg::*;

  localparam int M_IDLE   = 0;
  localparam int M_SEEDED = 1;
  localparam int M_ACT    = 2;
  localparam int M_DRAIN  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic [7:0]  seed_ID;
  logic [15:0] threshold;
  logic [1:0]  in_base;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out_base;
  logic        out_mut;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] site_cnt;
  logic [15:0] mut_cnt;
  logic        done;

  site_mutator #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .seed_ID   (seed_ID),
    .threshold (threshold),
    .in_base   (in_base),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_base  (out_base),
    .out_mut   (out_mut),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .site_cnt  (site_cnt),
    .mut_cnt   (mut_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] base;
    logic       mut;
    logic [1:0] parent;
  } item_t;

  item_t       q[$];
  logic [2:0]  out_log[$];
  logic [2:0]  exp_log[$];
  logic [1:0]  base_tab[64];
  int          base_mode;
  int          checks = 0;
  int          errors = 0;
  int          m_fsm;
  logic [31:0] m_rng;
  int          m_sites;
  int          m_muts;
  logic        m_done;
  logic        exp_rdy;
  logic [2:0]  first_entry;
  logic [7:0]  r_seed;
  logic [15:0] r_thr;
  int          r_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] seedw(input logic [7:0] s);
    return {s, ~s, s ^ 8'hA5, 8'h5A};
  endfunction

  function automatic item_t child_of(input logic [1:0] parent, input logic [31:0] r, input logic [15:0] thr);
    item_t it;
    int    off;
    it.parent = parent;
    it.mut    = (thr == 16'hFFFF) || (r[15:0] < thr);
    off       = int'(r[17:16]);
    if (off == 0) off = 2;
    it.base   = it.mut ? 2'((int'(parent) + off) % 4) : parent;
    return it;
  endfunction

  function automatic logic [1:0] base_of(input int i);
    logic [1:0] b;
    if (base_mode == 0) begin
      b = BASE_G;
    end else if (base_mode == 1) begin
      case (i % 4)
        0:       b = BASE_A;
        1:       b = BASE_C;
        2:       b = BASE_G;
        default: b = BASE_T;
      endcase
    end else begin
      b = base_tab[i % 64];
    end
    return b;
  endfunction

  // Compare process: check outputs against the model, then advance the model to the next edge
  always @(negedge clk) begin : mon
    item_t it;
    logic  hs;
    if (reset) begin
      m_fsm = M_IDLE; m_rng = 32'd1; m_sites = 0; m_muts = 0; m_done = 1'b0;
      q.delete();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_base", out_base, 0);
      chk("rst_out_mut", out_mut, 0);
      chk("rst_site_cnt", site_cnt, 0);
      chk("rst_mut_cnt", mut_cnt, 0);
      chk("rst_done", done, 0);
    end else begin
      exp_rdy = (m_fsm == M_ACT) && (state == PH_RUN) && ((q.size() == 0) || out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_base", out_base, q[0].base);
        chk("out_mut", out_mut, q[0].mut);
      end
      chk("site_cnt", site_cnt, m_sites);
      chk("mut_cnt", mut_cnt, m_muts);
      chk("done", done, m_done);
      if (!state[2]) begin
        hs = (q.size() != 0) && out_ready && (state != PH_IDLE);
        if (hs) begin
          if (q[0].mut) chk("mut_differs", out_base != q[0].parent, 1);
          out_log.push_back({out_mut, out_base});
          void'(q.pop_front());
        end
        case (state)
          PH_IDLE: begin
            m_fsm = M_IDLE; m_done = 1'b0; q.delete();
          end
          PH_SEED: begin
            m_rng = seedw(seed_ID); m_sites = 0; m_muts = 0; m_done = 1'b0;
            if (m_fsm == M_IDLE) m_fsm = M_SEEDED;
          end
          PH_RUN: begin
            m_done = 1'b0;
            if (exp_rdy && in_valid) begin
              it = child_of(in_base, m_rng, threshold);
              q.push_back(it);
              m_rng = xs(m_rng);
              if (m_sites < 65535) m_sites++;
              if (it.mut && m_muts < 65535) m_muts++;
            end
            if (m_fsm == M_SEEDED) m_fsm = M_ACT;
          end
          default: begin
            if (m_fsm == M_ACT) begin
              m_fsm = M_DRAIN; m_done = 1'b0;
            end else if (m_fsm == M_DRAIN) begin
              if (m_done) begin
                m_fsm = M_IDLE; m_done = 1'b0;
              end else begin
                m_done = (q.size() == 0);
              end
            end else begin
              m_done = 1'b0;
            end
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [7:0] s);
    state = PH_SEED;
    seed_ID = s;
    step();
    seed_ID = 8'($urandom);
    out_log.delete();
  endtask

  task automatic run_sites(input int n, input logic [15:0] thr, input int pv, input int pr,
                           input int stall_at, input int hold_at);
    int cyc;
    bit stalled;
    bit held;
    cyc = 0; stalled = 0; held = 0;
    threshold = thr;
    state = PH_RUN;
    while (m_sites < n && cyc < 3000) begin
      in_base   = base_of(m_sites);
      in_valid  = ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      if (!stalled && m_sites == stall_at && q.size() != 0) begin
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (5) begin
          step();
          chk("stall_in_ready", in_ready, 0);
        end
        stalled = 1;
      end
      if (!held && m_sites == hold_at) begin
        state = 3'b111; in_valid = 1'b1;
        repeat (4) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
        state = PH_RUN; held = 1;
      end
      step();
      cyc++;
    end
    chk("run_sites_count", m_sites, n);
    in_valid = 1'b0;
  endtask

  task automatic do_drain(input int pr);
    bit seen;
    int cyc;
    seen = 0; cyc = 0;
    state = PH_DRAIN;
    while (!seen && cyc < 200) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_base   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < pr);
      step();
      cyc++;
      if (done) seen = 1;
    end
    chk("drain_done_seen", seen, 1);
    in_valid = 1'b0;
    step();
    state = PH_IDLE;
    step();
  endtask

  task automatic compare_logs(input logic [7:0] s, input logic [15:0] thr, input int n);
    logic [31:0] r;
    item_t       it;
    r = seedw(s);
    exp_log.delete();
    for (int i = 0; i < n; i++) begin
      it = child_of(base_of(i), r, thr);
      exp_log.push_back({it.mut, it.base});
      r = xs(r);
    end
    chk("log_len", out_log.size(), n);
    for (int i = 0; i < n && i < out_log.size(); i++)
      chk($sformatf("log_entry[%0d]", i), out_log[i], exp_log[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; state = PH_IDLE; seed_ID = 8'h00; threshold = 16'h0000;
    in_base = 2'd0; in_valid = 1'b0; out_ready = 1'b0; base_mode = 0;
    for (int i = 0; i < 64; i++) base_tab[i] = 2'($urandom_range(0, 3));

    chk("model_xs_of_1", xs(32'd1), 32'h0004_2021);
    chk("model_seed_00", seedw(8'h00), 32'h00FF_A55A);
    chk("model_seed_12", seedw(8'h12), 32'h12ED_B75A);

    repeat (3) step();
    reset = 1'b0;
    step();

    // threshold 0: eight G sites pass through unchanged
    base_mode = 0;
    do_seed(8'h00);
    run_sites(8, 16'h0000, 100, 100, -1, -1);
    do_drain(100);
    compare_logs(8'h00, 16'h0000, 8);
    foreach (out_log[i]) chk("thr0_entry", out_log[i], 3'b010);
    chk("thr0_site_cnt", site_cnt, 8);
    chk("thr0_mut_cnt", mut_cnt, 0);

    // threshold all-ones: every site mutates, sequence from seed 0x00FFA55A
    base_mode = 1;
    do_seed(8'h00);
    run_sites(16, 16'hFFFF, 70, 70, -1, -1);
    do_drain(60);
    compare_logs(8'h00, 16'hFFFF, 16);
    first_entry = (out_log.size() > 0) ? out_log[0] : 3'b000;
    chk("all_mut_first", first_entry, 3'b111);
    foreach (out_log[i]) chk("all_mut_flag", out_log[i][2], 1);
    chk("all_mut_site_cnt", site_cnt, 16);
    chk("all_mut_mut_cnt", mut_cnt, 16);

    // five-cycle output stall mid-stream
    base_mode = 2;
    do_seed(8'h3C);
    run_sites(12, 16'h8000, 100, 100, 5, -1);
    do_drain(100);
    compare_logs(8'h3C, 16'h8000, 12);

    // HOLD mid-run, then the same run without HOLD: both must match the reference
    do_seed(8'h77);
    run_sites(20, 16'h4000, 100, 100, -1, 7);
    do_drain(100);
    compare_logs(8'h77, 16'h4000, 20);
    do_seed(8'h77);
    run_sites(20, 16'h4000, 100, 100, -1, -1);
    do_drain(100);
    compare_logs(8'h77, 16'h4000, 20);

    // reset pulse after three sites of a run
    do_seed(8'h5A);
    run_sites(3, 16'h6000, 100, 100, -1, -1);
    in_valid = 1'b1; out_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_run_site_cnt", site_cnt, 0);
    chk("rst_run_mut_cnt", mut_cnt, 0);
    chk("rst_run_out_valid", out_valid, 0);
    reset = 1'b0;
    out_log.delete();
    repeat (4) begin
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("post_rst_no_out", out_valid, 0);
    end
    chk("post_rst_log_empty", out_log.size(), 0);
    in_valid = 1'b0; state = PH_IDLE;
    step();
    do_seed(8'h5A);
    run_sites(10, 16'h6000, 80, 80, -1, -1);
    do_drain(100);
    compare_logs(8'h5A, 16'h6000, 10);

    // drain with one pending output: done one cycle after the last handshake
    do_seed(8'h99);
    run_sites(5, 16'h9000, 100, 100, -1, -1);
    out_ready = 1'b0; in_valid = 1'b1; state = PH_DRAIN;
    repeat (2) begin
      step();
      chk("drain_pending_valid", out_valid, 1);
      chk("drain_wait_done", done, 0);
    end
    out_ready = 1'b1;
    step();
    chk("drain_done_pulse", done, 1);
    chk("drain_empty", out_valid, 0);
    step();
    chk("drain_done_low", done, 0);
    state = PH_RUN; in_valid = 1'b1;
    step();
    chk("idle_after_drain_in_ready", in_ready, 0);
    state = PH_IDLE; in_valid = 1'b0;
    step();
    compare_logs(8'h99, 16'h9000, 5);

    // randomized runs with random backpressure, stalls and holds
    for (int k = 0; k < 6; k++) begin
      r_seed = 8'($urandom);
      r_thr  = 16'($urandom);
      r_n    = $urandom_range(5, 30);
      do_seed(r_seed);
      run_sites(r_n, r_thr, $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(0, r_n), (k % 2 == 1) ? $urandom_range(0, r_n - 1) : -1);
      do_drain(50);
      compare_logs(r_seed, r_thr, r_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/site_mutator.md
SITE_MUTATOR -- requirements
Module: site_mutator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the site and mutation counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port state, input, 3, phase code driven by Schedule.
REQ-005 SHALL have port seed_ID, input, 8, RNG seed; sampled only in the SEED phase.
REQ-006 SHALL have port threshold, input, 16, per-site mutation probability scaled by 2^16.
REQ-007 SHALL have ports in_base (2), in_valid (1) as inputs and in_ready (1) as output, the parent-site stream.
REQ-008 SHALL have ports out_base (2), out_mut (1), out_valid (1) as outputs and out_ready (1) as input, the child-site stream.
REQ-009 SHALL have outputs site_cnt (CNT_W), mut_cnt (CNT_W) and done (1).

Function
REQ-010 SHALL decode state as follows: 3'b000 IDLE, 3'b001 SEED, 3'b010 RUN, 3'b011 DRAIN; any other code SHALL be treated as HOLD, which freezes all registers.
REQ-011 SHALL implement internal FSM S_IDLE -> S_SEEDED -> S_ACTIVE -> S_DRAIN -> S_IDLE.
REQ-012 SHALL leave S_IDLE for S_SEEDED on state==SEED.
REQ-013 SHALL leave S_SEEDED for S_ACTIVE on state==RUN.
REQ-014 SHALL leave S_ACTIVE for S_DRAIN on state==DRAIN.
REQ-015 SHALL leave S_DRAIN for S_IDLE one cycle after done.
REQ-016 SHALL, in S_IDLE, return to S_IDLE from any FSM state when state==IDLE, clearing the output register.
REQ-017 SHALL, in SEED, load the 32-bit RNG with {seed_ID, ~seed_ID, seed_ID^8'hA5, 8'h5A}, which is never zero, and clear site_cnt and mut_cnt.
REQ-018 SHALL use xorshift32 for the RNG (x^=x<<13; x^=x>>17; x^=x<<5), advancing exactly once per accepted input site and holding otherwise.
REQ-019 SHALL assert in_ready only in S_ACTIVE, and only when the output register is empty or out_ready is high.
REQ-020 SHALL accept a site when in_valid && in_ready; the decision uses the current RNG value r.
REQ-021 SHALL mutate a site if threshold==16'hFFFF, or if r[15:0] < threshold (unsigned).
REQ-022 SHALL form a mutated base as (in_base + off) mod 4, where off = r[17:16] and off=0 is remapped to 2; a mutated base therefore always differs from the parent.
REQ-023 SHALL pass a non-mutated base through unchanged with out_mut=0.
REQ-024 SHALL register the result with 1-cycle latency: out_valid rises the cycle after acceptance.
REQ-025 SHALL hold out_base and out_mut stable while out_valid && !out_ready.
REQ-026 SHALL sustain one site per cycle when out_ready is held high.
REQ-027 SHALL increment site_cnt per accepted site and mut_cnt per mutated site, both saturating at all-ones with no wrap.
REQ-028 SHALL, when acceptance and drain occur in the same cycle, load the new result and keep out_valid high.
REQ-029 SHALL, in S_DRAIN, accept no new sites, and pulse done for 1 cycle once the output register is empty.
REQ-030 SHALL, in HOLD, keep in_ready=0, out_valid at its held value, and keep the RNG and counters frozen.

Reset
REQ-031 SHALL, while reset is high, asynchronously force FSM=S_IDLE, RNG=32'h0000_0001, out_valid=0, out_base=0, out_mut=0, site_cnt=0, mut_cnt=0, done=0, in_ready=0.
REQ-032 SHALL drop any in-flight site on reset mid-RUN, and emit no output until the next SEED/RUN sequence.

Structure
REQ-033 SHALL place the phase codes, the base encoding (A=0, C=1, G=2, T=3) and the seed-mixing constants 8'hA5 and 8'h5A in shared package alisim_pkg, which Schedule also uses.
REQ-034 SHALL place the RNG in one sub-module, xorshift32, with load, step and seed inputs and a 32-bit value output.

Verification
REQ-035 SHALL cover: reset, then SEED with seed_ID=0, then RUN; threshold=0 and 8 sites of in_base=2 -> 8 outputs with out_base=2 and out_mut=0, site_cnt=8, mut_cnt=0.
REQ-036 SHALL cover: threshold=16'hFFFF and 16 sites -> every out_mut=1, every out_base!=in_base, mut_cnt=16, with the sequence matching a xorshift32 reference model seeded 32'h00FFA55A.
REQ-037 SHALL cover: out_ready=0 for 5 cycles mid-stream -> in_ready=0 and out_base stable, with no site lost or duplicated after release.
REQ-038 SHALL cover: state=3'b111 for 4 cycles during RUN -> RNG, site_cnt and out_* unchanged, then resumption is identical to an unpaused run.
REQ-039 SHALL cover: reset pulse during RUN after 3 sites -> counters=0, out_valid=0; re-seeding with the same seed reproduces the original output sequence.
REQ-040 SHALL cover: DRAIN with one pending output and out_ready=1 -> done pulses exactly 1 cycle after the last out_valid handshake, then the FSM returns to S_IDLE.
